// File: rtl/lsu_ctrl.sv
// Load/store sequencer for the core MEM stage: one access at a time on a single data-memory port.
// Optional macro LSU_MISALIGNED_SPLIT_EN splits word-crossing accesses into two memory beats.
package lsu_pkg;
    typedef struct packed {
        logic        write_en;
        logic        read_en;
        logic [4:0]  lsuop;
        logic [31:0] addr;
        logic [31:0] data;
    } core_to_lsu_s;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        write_en;
    } lsu_to_core_s;

    typedef struct packed {
        logic        w_success;
        logic        r_success;
        logic [31:0] data;
    } mem_to_lsu_s;

    typedef struct packed {
        logic        write_en;
        logic        read_en;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } lsu_to_mem_s;

    // lsuop[1:0] = size (0 byte, 1 half, 2 word), lsuop[2] = zero-extend on loads
    localparam logic [4:0] LSU_LB  = 5'h00;
    localparam logic [4:0] LSU_LH  = 5'h01;
    localparam logic [4:0] LSU_LW  = 5'h02;
    localparam logic [4:0] LSU_LBU = 5'h04;
    localparam logic [4:0] LSU_LHU = 5'h05;
    localparam logic [4:0] LSU_SB  = 5'h08;
    localparam logic [4:0] LSU_SH  = 5'h09;
    localparam logic [4:0] LSU_SW  = 5'h0A;
endpackage

module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  core_to_lsu_s core_i,
    output lsu_to_core_s lsu_o,
    output logic         stall_o,
    output logic         done_o,
    output logic         fault_o,
    output logic         fault_cause_o,
    input  mem_to_lsu_s  mem_i,
    output lsu_to_mem_s  mem_o
);
`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, DONE, FAULT} state_t;
    state_t state_reg, state_next;

    logic          store_reg;
    logic [2:0]    op_reg;
    logic [31:0]   addr_reg, data_reg, lo_reg, hi_reg;
    logic [CW-1:0] cnt_reg;
    logic          cause_reg;

    logic          req, req_misaligned, success, timeout_hit, crosses, beat_active;
    logic [1:0]    off;
    logic [7:0]    pat;
    logic [63:0]   st_wide;
    logic [31:0]   ld_word, load_result;
    logic          unused_op;

    assign unused_op = ^core_i.lsuop[4:3];

    assign req = core_i.read_en | core_i.write_en;
    assign req_misaligned = (core_i.lsuop[1:0] == 2'd1 && core_i.addr[0]) ||
                            (core_i.lsuop[1] && core_i.addr[1:0] != 2'd0);

    // Strobe pattern spans two words; the upper nibble is the second beat.
    assign off = addr_reg[1:0];
    always_comb begin
        case (op_reg[1:0])
            2'd0:    pat = 8'b0000_0001 << off;
            2'd1:    pat = 8'b0000_0011 << off;
            default: pat = 8'b0000_1111 << off;
        endcase
    end
    assign crosses     = |pat[7:4];
    assign st_wide     = {32'b0, data_reg} << {off, 3'b000};
    assign ld_word     = 32'({hi_reg, lo_reg} >> {off, 3'b000});
    assign beat_active = (state_reg == BEAT0) || (state_reg == BEAT1);
    assign success     = store_reg ? mem_i.w_success : mem_i.r_success;
    assign timeout_hit = (cnt_reg == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        case (op_reg[1:0])
            2'd0:    load_result = op_reg[2] ? {24'b0, ld_word[7:0]}  : {{24{ld_word[7]}}, ld_word[7:0]};
            2'd1:    load_result = op_reg[2] ? {16'b0, ld_word[15:0]} : {{16{ld_word[15]}}, ld_word[15:0]};
            default: load_result = ld_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            store_reg <= 1'b0;
            op_reg    <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
            lo_reg    <= '0;
            hi_reg    <= '0;
            cnt_reg   <= '0;
            cause_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && req) begin
                store_reg <= core_i.write_en;
                op_reg    <= core_i.lsuop[2:0];
                addr_reg  <= core_i.addr;
                data_reg  <= core_i.data;
                hi_reg    <= '0;
                cnt_reg   <= '0;
                cause_reg <= 1'b0;
            end else if (beat_active) begin
                if (success) begin
                    if (state_reg == BEAT0) lo_reg <= mem_i.data;
                    else                    hi_reg <= mem_i.data;
                    cnt_reg <= '0;
                end else begin
                    if (cnt_reg != CW'(TIMEOUT_CYCLES)) cnt_reg <= cnt_reg + 1'b1;
                    if (timeout_hit) cause_reg <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        stall_o       = 1'b0;
        done_o        = 1'b0;
        fault_o       = 1'b0;
        fault_cause_o = 1'b0;
        lsu_o         = '0;
        mem_o         = '0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    stall_o    = 1'b1;
                    state_next = (req_misaligned && !SPLIT_EN) ? FAULT : BEAT0;
                end
            end
            BEAT0, BEAT1: begin
                stall_o        = 1'b1;
                mem_o.write_en = store_reg;
                mem_o.read_en  = !store_reg;
                mem_o.addr     = {addr_reg[31:2], 2'b00} + ((state_reg == BEAT1) ? 32'd4 : 32'd0);
                mem_o.strb     = (state_reg == BEAT1) ? pat[7:4] : pat[3:0];
                if (store_reg)
                    mem_o.data = (state_reg == BEAT1) ? st_wide[63:32] : st_wide[31:0];
                if (success)
                    state_next = (state_reg == BEAT0 && SPLIT_EN && crosses) ? BEAT1 : DONE;
                else if (timeout_hit)
                    state_next = FAULT;
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
                if (!store_reg) begin
                    lsu_o.write_en = 1'b1;
                    lsu_o.addr     = addr_reg;
                    lsu_o.data     = load_result;
                end
            end
            FAULT: begin
                fault_o       = 1'b1;
                fault_cause_o = cause_reg;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: byte-level memory model predicts completions, faults and memory contents.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst;
    core_to_lsu_s core_i;
    lsu_to_core_s lsu_o;
    logic         stall_o, done_o, fault_o, fault_cause_o;
    mem_to_lsu_s  mem_i;
    lsu_to_mem_s  mem_o;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .core_i(core_i), .lsu_o(lsu_o), .stall_o(stall_o),
        .done_o(done_o), .fault_o(fault_o), .fault_cause_o(fault_cause_o),
        .mem_i(mem_i), .mem_o(mem_o)
    );

    typedef struct {
        bit          is_load;
        bit          fault;
        bit          cause;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
        logic        we;
    } beat_t;

    exp_t  sb[$];
    beat_t beats[$];
    int    checks = 0;
    int    errors = 0;
    int    resp_lat = 0;
    int    en_cycles = 0;
    int    beat_cyc = 0;
    logic [31:0] resp_mem [logic [31:0]];
    logic [31:0] exp_mem  [logic [31:0]];

    function automatic logic [7:0] exp_byte(input logic [31:0] a);
        logic [31:0] w, v;
        w = {a[31:2], 2'b00};
        if (!exp_mem.exists(w)) return 8'h00;
        v = exp_mem[w];
        return v[8*a[1:0] +: 8];
    endfunction

    function automatic void set_byte(input logic [31:0] a, input logic [7:0] b);
        logic [31:0] w, v;
        w = {a[31:2], 2'b00};
        v = exp_mem.exists(w) ? exp_mem[w] : 32'h0;
        v[8*a[1:0] +: 8] = b;
        exp_mem[w] = v;
    endfunction

    task automatic preload(input logic [31:0] w, input logic [31:0] v);
        resp_mem[w] = v;
        exp_mem[w]  = v;
    endtask

    // Memory responder: success after resp_lat waiting cycles of each beat.
    always @(negedge clk) begin : responder
        beat_t       b;
        logic [31:0] w;
        mem_i = '0;
        if (rst) begin
            beat_cyc = 0;
        end else if (mem_o.read_en || mem_o.write_en) begin
            if (beat_cyc == 0) begin
                b.addr = mem_o.addr; b.strb = mem_o.strb; b.data = mem_o.data; b.we = mem_o.write_en;
                beats.push_back(b);
            end
            en_cycles++;
            if (beat_cyc >= resp_lat) begin
                w = resp_mem.exists(mem_o.addr) ? resp_mem[mem_o.addr] : 32'h0;
                if (mem_o.write_en) begin
                    mem_i.w_success = 1'b1;
                    for (int i = 0; i < 4; i++)
                        if (mem_o.strb[i]) w[8*i +: 8] = mem_o.data[8*i +: 8];
                    resp_mem[mem_o.addr] = w;
                end else begin
                    mem_i.r_success = 1'b1;
                    mem_i.data      = w;
                end
                beat_cyc = 0;
            end else begin
                beat_cyc++;
            end
        end else begin
            beat_cyc = 0;
        end
    end

    // Completion monitor: pops the scoreboard on every done/fault pulse.
    exp_t m;
    always @(negedge clk) begin
        if (!rst) begin
            if (done_o || fault_o) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_end: done=%0d fault=%0d, required no completion", done_o, fault_o);
                end else begin
                    m = sb.pop_front();
                    checks++;
                    if (fault_o !== m.fault || done_o !== !m.fault) begin
                        errors++;
                        $display("FAIL end_kind addr=%h: done=%0d fault=%0d, required fault=%0d", m.addr, done_o, fault_o, m.fault);
                    end
                    if (m.fault) begin
                        checks++;
                        if (fault_cause_o !== m.cause) begin
                            errors++;
                            $display("FAIL fault_cause addr=%h: got %0d, required %0d", m.addr, fault_cause_o, m.cause);
                        end
                    end
                    checks++;
                    if (lsu_o.write_en !== (m.is_load && !m.fault)) begin
                        errors++;
                        $display("FAIL wb_en addr=%h: got %0d, required %0d", m.addr, lsu_o.write_en, m.is_load && !m.fault);
                    end
                    if (m.is_load && !m.fault) begin
                        checks++;
                        if (lsu_o.data !== m.data || lsu_o.addr !== m.addr) begin
                            errors++;
                            $display("FAIL wb_data: got addr=%h data=%h, required addr=%h data=%h", lsu_o.addr, lsu_o.data, m.addr, m.data);
                        end
                    end
                    checks++;
                    if (stall_o !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_at_end addr=%h: got %0d, required 0", m.addr, stall_o);
                    end
                    $display("txn addr=%h load=%0d fault=%0d cause=%0d data=%h", m.addr, m.is_load, fault_o, fault_cause_o, lsu_o.data);
                end
            end else begin
                checks++;
                if (lsu_o.write_en !== 1'b0) begin
                    errors++;
                    $display("FAIL wb_en_idle: got %0d, required 0", lsu_o.write_en);
                end
            end
        end
    end

    task automatic run_access(input logic [4:0] op, input logic [31:0] a, input logic [31:0] d,
                              input bit store, input bit both, input int lat, input bit no_wait,
                              output int end_cyc);
        exp_t        e;
        int          sz;
        bit          misal;
        logic [31:0] r;
        sz    = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
        misal = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'd0);
        e.is_load = !store; e.addr = a; e.data = 32'h0; e.fault = 1'b0; e.cause = 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
        misal = 1'b0;
`endif
        if (misal) begin
            e.fault = 1'b1; e.cause = 1'b0;
        end else if (lat >= TO) begin
            e.fault = 1'b1; e.cause = 1'b1;
        end else if (store) begin
            for (int i = 0; i < sz; i++) set_byte(a + i, d[8*i +: 8]);
        end else begin
            r = 32'h0;
            for (int i = 0; i < sz; i++) r[8*i +: 8] = exp_byte(a + i);
            if (!op[2] && sz == 1) r = {{24{r[7]}}, r[7:0]};
            if (!op[2] && sz == 2) r = {{16{r[15]}}, r[15:0]};
            e.data = r;
        end
        sb.push_back(e);
        if (!no_wait) @(negedge clk);
        resp_lat = lat; en_cycles = 0; beats.delete();
        core_i.write_en = store; core_i.read_en = !store || both;
        core_i.lsuop = op; core_i.addr = a; core_i.data = d;
        end_cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!stall_o) begin end_cyc = c; break; end
        end
        core_i = '0;
        if (end_cyc < 0) begin
            checks++; errors++;
            $display("FAIL access_timeout addr=%h: stall_o never dropped within 40 cycles", a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; core_i = '0; mem_i = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (lsu_o !== '0 || mem_o !== '0) begin
                errors++; $display("FAIL reset_buses: lsu_o=%h mem_o=%h, required 0", lsu_o, mem_o);
            end
            checks++;
            if ({stall_o, done_o, fault_o, fault_cause_o} !== 4'b0) begin
                errors++; $display("FAIL reset_flags: stall/done/fault/cause=%b, required 0000", {stall_o, done_o, fault_o, fault_cause_o});
            end
            rst = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_load_ext();
        int n;
        preload(32'h1000, 32'h80FF_0000);
        run_access(LSU_LB,  32'h1003, 32'h0, 0, 0, 0, 0, n);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL load_latency: done in cycle %0d, required 2", n); end
        run_access(LSU_LBU, 32'h1003, 32'h0, 0, 0, 0, 0, n);
        run_access(LSU_LH,  32'h1002, 32'h0, 0, 0, 0, 0, n);
        run_access(LSU_LHU, 32'h1002, 32'h0, 0, 0, 0, 0, n);
        run_access(LSU_LW,  32'h1000, 32'h0, 0, 0, 1, 0, n);
    endtask

    task automatic test_store();
        int n;
        preload(32'h2000, 32'h1122_3344);
        preload(32'h2004, 32'h0);
        run_access(LSU_SH, 32'h2002, 32'h0000_BEEF, 1, 0, 0, 0, n);
        checks++;
        if (beats.size() != 1 || beats[0].addr !== 32'h2000 || beats[0].strb !== 4'b1100 ||
            beats[0].data !== 32'hBEEF_0000 || beats[0].we !== 1'b1) begin
            errors++;
            $display("FAIL sh_beat: beats=%0d addr=%h strb=%b data=%h we=%0d, required 1 2000 1100 beef0000 1",
                     beats.size(), beats.size() ? beats[0].addr : 32'h0, beats.size() ? beats[0].strb : 4'h0,
                     beats.size() ? beats[0].data : 32'h0, beats.size() ? beats[0].we : 1'b0);
        end
        run_access(LSU_SB, 32'h2001, 32'h0000_00AA, 1, 0, 1, 0, n);
        run_access(LSU_SW, 32'h2004, 32'hDEAD_C0DE, 1, 1, 0, 0, n);
        checks++;
        if (beats.size() != 1 || beats[0].we !== 1'b1) begin
            errors++; $display("FAIL write_wins: beats=%0d, required one write beat", beats.size());
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (resp_mem[32'h2000 + 4*k] !== exp_mem[32'h2000 + 4*k]) begin
                errors++; $display("FAIL store_mem word %0d: got %h, required %h", k, resp_mem[32'h2000 + 4*k], exp_mem[32'h2000 + 4*k]);
            end
        end
        run_access(LSU_LW, 32'h2000, 32'h0, 0, 0, 0, 0, n);
    endtask

    task automatic test_latency();
        int n;
        preload(32'h0010, 32'hCAFE_F00D);
        run_access(LSU_LW, 32'h0010, 32'h0, 0, 0, 3, 0, n);
        checks++;
        if (en_cycles != 4 || n !== 5) begin
            errors++; $display("FAIL slow_load: enable cycles=%0d done cycle=%0d, required 4 and 5", en_cycles, n);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        run_access(LSU_LW, 32'h0010, 32'h0, 0, 0, 0, 0, n);
        run_access(LSU_LW, 32'h1000, 32'h0, 0, 0, 0, 1, n);
        checks++;
        if (n !== 3 || en_cycles != 1) begin
            errors++; $display("FAIL back_to_back: done cycle=%0d enables=%0d, required 3 and 1", n, en_cycles);
        end
    endtask

    task automatic test_timeout();
        int n;
        run_access(LSU_LW, 32'h0010, 32'h0, 0, 0, 100, 0, n);
        checks++;
        if (en_cycles != TO || n !== TO + 1) begin
            errors++; $display("FAIL timeout_load: enables=%0d fault cycle=%0d, required %0d and %0d", en_cycles, n, TO, TO + 1);
        end
        run_access(LSU_SW, 32'h2004, 32'h1234_5678, 1, 0, 100, 0, n);
        checks++;
        if (resp_mem[32'h2004] !== exp_mem[32'h2004]) begin
            errors++; $display("FAIL timeout_store_mem: got %h, required %h", resp_mem[32'h2004], exp_mem[32'h2004]);
        end
    endtask

    task automatic test_misaligned();
        int n;
        preload(32'h3000, 32'h5566_7788);
        preload(32'h3004, 32'h1122_3344);
        run_access(LSU_LW, 32'h3002, 32'h0, 0, 0, 0, 0, n);
`ifdef LSU_MISALIGNED_SPLIT_EN
        checks++;
        if (beats.size() != 2 || n !== 3) begin
            errors++; $display("FAIL split_beats: beats=%0d done cycle=%0d, required 2 and 3", beats.size(), n);
        end else begin
            checks++;
            if (beats[0].addr !== 32'h3000 || beats[0].strb !== 4'b1100 ||
                beats[1].addr !== 32'h3004 || beats[1].strb !== 4'b0011) begin
                errors++; $display("FAIL split_addr: %h/%b %h/%b, required 3000/1100 3004/0011",
                                   beats[0].addr, beats[0].strb, beats[1].addr, beats[1].strb);
            end
        end
`else
        checks++;
        if (en_cycles != 0 || n !== 1) begin
            errors++; $display("FAIL misaligned_fault: enables=%0d fault cycle=%0d, required 0 and 1", en_cycles, n);
        end
`endif
        run_access(LSU_SH,  32'h3003, 32'h0000_A1B2, 1, 0, 0, 0, n);
        run_access(LSU_LHU, 32'h1001, 32'h0, 0, 0, 0, 0, n);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (resp_mem[32'h3000 + 4*k] !== exp_mem[32'h3000 + 4*k]) begin
                errors++; $display("FAIL misaligned_mem word %0d: got %h, required %h", k, resp_mem[32'h3000 + 4*k], exp_mem[32'h3000 + 4*k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        resp_lat = 100;
        core_i.write_en = 1'b0; core_i.read_en = 1'b1; core_i.lsuop = LSU_LW;
        core_i.addr = 32'h0010; core_i.data = 32'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_o.read_en !== 1'b1) begin
            errors++; $display("FAIL mid_beat: read_en=%0d, required 1", mem_o.read_en);
        end
        rst = 1'b1; core_i = '0;
        @(negedge clk);
        checks++;
        if (mem_o.read_en !== 1'b0 || mem_o.write_en !== 1'b0 || stall_o !== 1'b0) begin
            errors++; $display("FAIL reset_mid: re=%0d we=%0d stall=%0d, required 0 0 0", mem_o.read_en, mem_o.write_en, stall_o);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        $display("txn reset mid-access, controller idle");
    endtask

    initial begin
        test_reset();
        test_load_ext();
        test_store();
        test_latency();
        test_back_to_back();
        test_timeout();
        test_misaligned();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
